// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler: pipeline (A) writes own the port, multi-cycle (B) writes queue in a FIFO.
// Optional macro RF_SCHED_SCOREBOARD_EN adds per-register pending tracking and src hazard detection.
module rf_write_scheduler #(
    parameter int STARVE_LIMIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_en,
    input  logic [3:0]  a_dest,
    input  logic [31:0] a_value,
    input  logic        b_valid,
    input  logic [3:0]  b_dest,
    input  logic [31:0] b_value,
    output logic        b_ready,
    input  logic        issue_en,
    input  logic [3:0]  issue_dest,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    output logic        hazard,
    output logic [14:0] pending,
    output logic        stall_req,
    output logic        WB_En,
    output logic [3:0]  Dest_WB,
    output logic [31:0] WB_Value,
    output logic        err_dest
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [3:0]    mem_dest  [FIFO_DEPTH];
    logic [31:0]   mem_value [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          wb_en_q, wb_en_d;
    logic [3:0]    wb_dest_q, wb_dest_d;
    logic [31:0]   wb_value_q, wb_value_d;
    logic          err_q, err_d;

    logic          full, empty, push, pop;
    logic [3:0]    head_dest;
    logic [31:0]   head_value;

    always_comb begin
        full       = (count_q == CW'(FIFO_DEPTH));
        empty      = (count_q == '0);
        // Gating with rst keeps b_ready low while reset is held.
        b_ready    = rst && !full;
        push       = b_valid && b_ready;
        pop        = !a_en && !empty;
        head_dest  = mem_dest[rd_ptr_q];
        head_value = mem_value[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        starve_d = '0;
        if (a_en && !empty) begin
            starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
        end
    end

    always_comb begin
        wb_en_d    = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_value_d = wb_value_q;
        err_d      = err_q;
        if (a_en) begin
            if (a_dest == 4'hF) begin
                err_d = 1'b1;
            end else begin
                wb_en_d    = 1'b1;
                wb_dest_d  = a_dest;
                wb_value_d = a_value;
            end
        end else if (!empty) begin
            // R15 entries still leave the FIFO; they just never reach the port.
            if (head_dest == 4'hF) begin
                err_d = 1'b1;
            end else begin
                wb_en_d    = 1'b1;
                wb_dest_d  = head_dest;
                wb_value_d = head_value;
            end
        end
`ifdef RF_SCHED_SCOREBOARD_EN
        if (issue_en && issue_dest == 4'hF) begin
            err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            wb_en_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_value_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            wb_en_q    <= wb_en_d;
            wb_dest_q  <= wb_dest_d;
            wb_value_q <= wb_value_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_dest[wr_ptr_q]  <= b_dest;
            mem_value[wr_ptr_q] <= b_value;
        end
    end

    assign stall_req = (starve_q == SW'(STARVE_LIMIT));
    assign WB_En     = wb_en_q;
    assign Dest_WB   = wb_dest_q;
    assign WB_Value  = wb_value_q;
    assign err_dest  = err_q;

`ifdef RF_SCHED_SCOREBOARD_EN
    logic [14:0] pend_q, pend_d;
    logic [15:0] pend_ext;

    always_comb begin
        pend_d = pend_q;
        for (int r = 0; r < 15; r++) begin
            if (pop && head_dest == 4'(r)) pend_d[r] = 1'b0;
            // Set after clear so a same-cycle reissue keeps the bit.
            if (issue_en && issue_dest == 4'(r)) pend_d[r] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_ext = {1'b0, pend_q};
    assign pending  = pend_q;
    assign hazard   = pend_ext[src1] | pend_ext[src2];
`else
    logic unused_sb;
    assign unused_sb = ^{issue_en, issue_dest, src1, src2};
    assign pending   = '0;
    assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: single-request vector table plus multi-cycle arbitration,
// FIFO-full, starvation, scoreboard and reset sequences.
module tb_rf_write_scheduler;
`ifdef RF_SCHED_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, b_valid, issue_en;
    logic [3:0]  a_dest, b_dest, issue_dest, src1, src2;
    logic [31:0] a_value, b_value;
    logic        b_ready, hazard, stall_req, WB_En, err_dest;
    logic [14:0] pending;
    logic [3:0]  Dest_WB;
    logic [31:0] WB_Value;

    logic [31:0] rf [16];
    int vec_cnt  = 0;
    int miss_cnt = 0;

    typedef struct {
        logic        a_en;
        logic [3:0]  a_dest;
        logic [31:0] a_val;
        logic        b_valid;
        logic [3:0]  b_dest;
        logic [31:0] b_val;
        int          lat;
        logic        exp_en;
        logic [3:0]  exp_dest;
        logic [31:0] exp_val;
        logic        exp_err;
    } vec_t;

    vec_t vt [6];
    logic [3:0]  dq [5];
    logic [31:0] vq [5];

    rf_write_scheduler #(.STARVE_LIMIT(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_dest(a_dest), .a_value(a_value),
        .b_valid(b_valid), .b_dest(b_dest), .b_value(b_value), .b_ready(b_ready),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .src1(src1), .src2(src2), .hazard(hazard), .pending(pending),
        .stall_req(stall_req), .WB_En(WB_En), .Dest_WB(Dest_WB), .WB_Value(WB_Value),
        .err_dest(err_dest)
    );

    always #5 clk = ~clk;

    // Register file commits at the negedge following the registered write.
    always @(negedge clk) begin
        if (WB_En) rf[Dest_WB] <= WB_Value;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_en = 1'b0; a_dest = '0; a_value = '0;
        b_valid = 1'b0; b_dest = '0; b_value = '0;
        issue_en = 1'b0; issue_dest = '0; src1 = '0; src2 = '0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_wb_en"}, WB_En, 0);
        chk({tag, "_dest"}, Dest_WB, 0);
        chk({tag, "_value"}, WB_Value, 0);
        chk({tag, "_stall"}, stall_req, 0);
        chk({tag, "_err"}, err_dest, 0);
        chk({tag, "_pending"}, pending, 0);
        chk({tag, "_hazard"}, hazard, 0);
        chk({tag, "_b_ready"}, b_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miss_cnt);
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 4'd0,  32'h0,        1, 1'b1, 4'd3,  32'hDEADBEEF, 1'b0};
        vt[1] = '{1'b1, 4'd0,  32'h00000001, 1'b0, 4'd0,  32'h0,        1, 1'b1, 4'd0,  32'h00000001, 1'b0};
        vt[2] = '{1'b1, 4'd14, 32'hFFFFFFFF, 1'b0, 4'd0,  32'h0,        1, 1'b1, 4'd14, 32'hFFFFFFFF, 1'b0};
        vt[3] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd5,  32'h12345678, 2, 1'b1, 4'd5,  32'h12345678, 1'b0};
        vt[4] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd14, 32'hA5A5A5A5, 2, 1'b1, 4'd14, 32'hA5A5A5A5, 1'b0};
        vt[5] = '{1'b1, 4'd15, 32'h0BADF00D, 1'b0, 4'd0,  32'h0,        1, 1'b0, 4'd0,  32'h0,        1'b1};

        idle();
        rst = 1'b0;
        tick();
        tick();
        chk_reset_state("rst0");
        rst = 1'b1;
        #1;
        chk("rst0_b_ready_rise", b_ready, 1);

        for (int i = 0; i < 6; i++) begin
            a_en = vt[i].a_en; a_dest = vt[i].a_dest; a_value = vt[i].a_val;
            b_valid = vt[i].b_valid; b_dest = vt[i].b_dest; b_value = vt[i].b_val;
            #1;
            chk($sformatf("tbl%0d_b_ready", i), b_ready, 1);
            tick();
            idle();
            if (vt[i].lat == 2) tick();
            chk($sformatf("tbl%0d_wb_en", i), WB_En, vt[i].exp_en);
            if (vt[i].exp_en) begin
                chk($sformatf("tbl%0d_dest", i), Dest_WB, vt[i].exp_dest);
                chk($sformatf("tbl%0d_value", i), WB_Value, vt[i].exp_val);
            end
            chk($sformatf("tbl%0d_err", i), err_dest, vt[i].exp_err);
            tick();
            chk($sformatf("tbl%0d_no_dup", i), WB_En, 0);
            if (vt[i].exp_en) chk($sformatf("tbl%0d_rf", i), rf[vt[i].exp_dest], vt[i].exp_val);
        end

        // A and B together: A first, B on the next A-free cycle.
        a_en = 1'b1; a_dest = 4'd2; a_value = 32'h11111111;
        b_valid = 1'b1; b_dest = 4'd5; b_value = 32'h55555555;
        tick();
        idle();
        chk("ab_first_dest", Dest_WB, 2);
        chk("ab_first_value", WB_Value, 32'h11111111);
        tick();
        chk("ab_second_en", WB_En, 1);
        chk("ab_second_dest", Dest_WB, 5);
        chk("ab_second_value", WB_Value, 32'h55555555);
        tick();
        chk("ab_done", WB_En, 0);

        // Fill the FIFO behind a busy A stream, hold a fifth request, then drain.
        a_en = 1'b1; a_dest = 4'd1;
        for (int k = 0; k < 4; k++) begin
            a_value = 32'hA0 + k;
            b_valid = 1'b1; b_dest = 4'(k + 1); b_value = 32'hB1 + k;
            #1;
            chk($sformatf("fill%0d_ready", k), b_ready, 1);
            tick();
            chk($sformatf("fill%0d_wb_a", k), WB_Value, 32'hA0 + k);
        end
        b_dest = 4'd6; b_value = 32'hB5;
        #1;
        chk("full_ready", b_ready, 0);
        tick();
        chk("held1_ready", b_ready, 0);
        tick();
        chk("held2_ready", b_ready, 0);
        chk("held_stall", stall_req, 0);
        dq[0] = 4'd1; dq[1] = 4'd2; dq[2] = 4'd3; dq[3] = 4'd4; dq[4] = 4'd6;
        vq[0] = 32'hB1; vq[1] = 32'hB2; vq[2] = 32'hB3; vq[3] = 32'hB4; vq[4] = 32'hB5;
        a_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("drain%0d_en", k), WB_En, 1);
            chk($sformatf("drain%0d_dest", k), Dest_WB, dq[k]);
            chk($sformatf("drain%0d_value", k), WB_Value, vq[k]);
            if (k == 0) chk("drain_ready_after_pop", b_ready, 1);
            if (k == 1) b_valid = 1'b0;
        end
        tick();
        chk("drain_empty", WB_En, 0);

        // Starvation: one queued B entry behind continuous A writes.
        idle();
        b_valid = 1'b1; b_dest = 4'd8; b_value = 32'hC8;
        tick();
        b_valid = 1'b0;
        a_en = 1'b1; a_dest = 4'd2; a_value = 32'hA8;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("stall_c%0d", k), stall_req, (k == 8) ? 1 : 0);
        end
        a_value = 32'hA9;
        tick();
        chk("stall_sat", stall_req, 1);
        chk("stall_a_wins_dest", Dest_WB, 2);
        chk("stall_a_wins_value", WB_Value, 32'hA9);
        a_en = 1'b0;
        tick();
        chk("stall_pop_dest", Dest_WB, 8);
        chk("stall_pop_value", WB_Value, 32'hC8);
        chk("stall_cleared", stall_req, 0);
        a_en = 1'b1;
        tick();
        chk("stall_empty", stall_req, 0);
        idle();
        tick();

        // Scoreboard: set by issue, untouched by A, cleared by B pop, set wins on collision.
        issue_en = 1'b1; issue_dest = 4'd7;
        tick();
        issue_en = 1'b0; src1 = 4'd7; src2 = 4'd0;
        #1;
        chk("sb_hazard_src1", hazard, SB);
        chk("sb_pending7", pending, 32'(SB) << 7);
        src1 = 4'd15; src2 = 4'd7;
        #1;
        chk("sb_hazard_src2", hazard, SB);
        src2 = 4'd15;
        #1;
        chk("sb_hazard_r15", hazard, 0);
        src1 = 4'd7;
        a_en = 1'b1; a_dest = 4'd7; a_value = 32'h77;
        tick();
        a_en = 1'b0;
        chk("sb_a_keeps", pending, 32'(SB) << 7);
        b_valid = 1'b1; b_dest = 4'd7; b_value = 32'h7777;
        tick();
        b_valid = 1'b0;
        chk("sb_queued_hazard", hazard, SB);
        tick();
        chk("sb_b_dest", Dest_WB, 7);
        chk("sb_cleared_hazard", hazard, 0);
        chk("sb_cleared_pending", pending, 0);
        issue_en = 1'b1; issue_dest = 4'd9;
        tick();
        issue_en = 1'b0;
        b_valid = 1'b1; b_dest = 4'd9; b_value = 32'h99;
        tick();
        b_valid = 1'b0; issue_en = 1'b1; issue_dest = 4'd9;
        tick();
        issue_en = 1'b0; src1 = 4'd9;
        chk("sb_set_wins", pending, 32'(SB) << 9);
        chk("sb_set_wins_hazard", hazard, SB);
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        tick();
        chk("sb_final_clear", pending, 0);

        // R15 handling and mid-operation reset.
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        a_en = 1'b1; a_dest = 4'd15; a_value = 32'hF00D;
        tick();
        a_en = 1'b0;
        chk("r15_a_no_wb", WB_En, 0);
        chk("r15_a_err", err_dest, 1);
        a_en = 1'b1; a_dest = 4'd4; a_value = 32'h44;
        tick();
        chk("r15_next_wb", WB_En, 1);
        chk("r15_sticky", err_dest, 1);
        a_dest = 4'd5;
        for (int k = 0; k < 3; k++) begin
            b_valid = 1'b1; b_dest = 4'(k + 1); b_value = 32'hE0 + k;
            issue_en = (k == 2); issue_dest = 4'd3;
            tick();
        end
        src1 = 4'd3;
        rst = 1'b0;
        tick();
        chk_reset_state("rst1");
        rst = 1'b1;
        idle();
        src1 = 4'd3;
        #1;
        chk("rst1_b_ready_rise", b_ready, 1);
        tick();
        chk("rst1_flushed_a", WB_En, 0);
        tick();
        chk("rst1_flushed_b", WB_En, 0);
        b_valid = 1'b1; b_dest = 4'd15; b_value = 32'hFF;
        tick();
        b_valid = 1'b0;
        tick();
        chk("r15_b_no_wb", WB_En, 0);
        chk("r15_b_err", err_dest, 1);
        chk("r15_b_popped", b_ready, 1);
        tick();
        chk("r15_b_gone", WB_En, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        issue_en = 1'b1; issue_dest = 4'd15;
        tick();
        issue_en = 1'b0;
        chk("r15_issue_err", err_dest, SB);
        chk("r15_issue_pending", pending, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
